// File: rtl/sm_trace_buf_pkg.sv
// sm_trace_buf_pkg: shared definitions for the schoolMIPS trace buffer.
//   - tr_state_e : capture state encodings (TR_IDLE=0, TR_PRE=1,
//                  TR_POST=2, TR_DONE=3), used by the RTL and the bench.
//   - TR_DEF_*   : default parameter values for sm_trace_buf.
package sm_trace_buf_pkg;

    typedef enum logic [1:0] {
        TR_IDLE = 2'd0,
        TR_PRE  = 2'd1,
        TR_POST = 2'd2,
        TR_DONE = 2'd3
    } tr_state_e;

    localparam int unsigned TR_DEF_DEPTH   = 16;
    localparam int unsigned TR_DEF_AW      = 4;
    localparam int unsigned TR_DEF_PC_W    = 32;
    localparam int unsigned TR_DEF_POST    = 4;
    localparam int unsigned TR_DEF_TIMEOUT = 120;

endpackage

// File: rtl/sm_trace_ram.sv
// sm_trace_ram: simple dual-port RAM for the trace buffer.
// Ports:
//   clk, rst_n       - clock, async active-low reset (read register only)
//   i_we/i_waddr/i_wdata - synchronous write port
//   i_raddr          - read address
//   o_rdata          - registered read data (resets to 0; array is not reset)
module sm_trace_ram #(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned AW    = 4,
    parameter int unsigned DW    = 64
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_we,
    input  logic [AW-1:0] i_waddr,
    input  logic [DW-1:0] i_wdata,
    input  logic [AW-1:0] i_raddr,
    output logic [DW-1:0] o_rdata
);

    logic [DW-1:0] r_mem [DEPTH];
    logic [DW-1:0] r_rdata;

    always_ff @(posedge clk) begin
        if (i_we)
            r_mem[i_waddr] <= i_wdata;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_rdata <= '0;
        else
            r_rdata <= r_mem[i_raddr];
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/sm_trace_buf.sv
// sm_trace_buf: on-chip instruction trace buffer for the schoolMIPS core.
// Records {pc, instr} per sampled cycle into a circular RAM; capture stops
// POST samples after a PC-match trigger and the history is read back by index
// (rd_idx 0 = oldest entry, one-cycle registered read).
// Ports:
//   clk, rst_n            - CPU clock, async active-low reset
//   sample_en, pc, instr  - trace sample input
//   arm                   - pulse: (re)start capture
//   trig_en, trig_pc      - PC-match trigger
//   rd_idx / rd_data      - indexed readout
//   count, busy, done     - capture status
//   timeout               - sticky: capture ended by the sample limit
// Optional feature: define SM_TRACE_TIMEOUT_EN to build the TIMEOUT sample
// limit; otherwise timeout is tied to 0.
module sm_trace_buf
    import sm_trace_buf_pkg::*;
#(
    parameter int unsigned DEPTH   = TR_DEF_DEPTH,
    parameter int unsigned AW      = TR_DEF_AW,
    parameter int unsigned PC_W    = TR_DEF_PC_W,
    parameter int unsigned POST    = TR_DEF_POST,
    parameter int unsigned TIMEOUT = TR_DEF_TIMEOUT
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               sample_en,
    input  logic [31:0]        pc,
    input  logic [31:0]        instr,
    input  logic               arm,
    input  logic               trig_en,
    input  logic [31:0]        trig_pc,
    input  logic [AW-1:0]      rd_idx,
    output logic [PC_W+31:0]   rd_data,
    output logic [AW:0]        count,
    output logic               busy,
    output logic               done,
    output logic               timeout
);

    localparam logic [AW:0]   L_DEPTH = (AW+1)'(DEPTH);
    localparam logic [AW-1:0] L_POST  = AW'(POST);

    tr_state_e     r_state, w_state_nxt;
    logic [AW-1:0] r_wr_ptr;
    logic [AW:0]   r_count;
    logic [AW-1:0] r_post_cnt;
    logic          r_timeout;

    logic          w_capt;
    logic          w_wr;
    logic          w_trig;
    logic          w_last_post;
    logic          w_to_hit;
    logic [AW-1:0] w_rd_addr;

    assign w_capt      = (r_state == TR_PRE) || (r_state == TR_POST);
    // arm takes priority: no write in the cycle a new capture starts
    assign w_wr        = w_capt && sample_en && !arm;
    assign w_trig      = (r_state == TR_PRE) && sample_en && trig_en &&
                         (pc[PC_W-1:0] == trig_pc[PC_W-1:0]);
    assign w_last_post = (r_state == TR_POST) && sample_en && (r_post_cnt == AW'(1));

`ifdef SM_TRACE_TIMEOUT_EN
    localparam int unsigned TW = $clog2(TIMEOUT + 1);
    logic [TW-1:0] r_to_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_to_cnt <= '0;
        else if (arm)
            r_to_cnt <= '0;
        else if (w_wr)
            r_to_cnt <= r_to_cnt + TW'(1);
    end

    // The write bringing the count to TIMEOUT ends the capture
    assign w_to_hit = w_wr && (r_to_cnt == TW'(TIMEOUT - 1));
`else
    logic w_unused_to;
    assign w_unused_to = (TIMEOUT != 0);
    assign w_to_hit    = 1'b0;
`endif

    // Upper pc/trig_pc bits are dropped when PC_W < 32
    logic w_unused_pc;
    assign w_unused_pc = ^{pc, trig_pc};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_state <= TR_IDLE;
        else
            r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        if (arm)
            w_state_nxt = TR_PRE;
        else if (w_to_hit)
            w_state_nxt = TR_DONE;
        else begin
            case (r_state)
                TR_PRE:  if (w_trig)      w_state_nxt = (POST == 0) ? TR_DONE : TR_POST;
                TR_POST: if (w_last_post) w_state_nxt = TR_DONE;
                default: w_state_nxt = r_state;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr   <= '0;
            r_count    <= '0;
            r_post_cnt <= '0;
            r_timeout  <= 1'b0;
        end else if (arm) begin
            r_wr_ptr   <= '0;
            r_count    <= '0;
            r_post_cnt <= '0;
            r_timeout  <= 1'b0;
        end else begin
            if (w_wr) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
                if (r_count != L_DEPTH)
                    r_count <= r_count + (AW+1)'(1);
            end
            if (w_trig)
                r_post_cnt <= L_POST;
            else if ((r_state == TR_POST) && sample_en)
                r_post_cnt <= r_post_cnt - AW'(1);
            if (w_to_hit)
                r_timeout <= 1'b1;
        end
    end

    // Oldest entry sits count slots behind the write pointer; when full the
    // low bits of count are 0 and the oldest entry is at wr_ptr itself.
    assign w_rd_addr = r_wr_ptr - r_count[AW-1:0] + rd_idx;

    sm_trace_ram #(
        .DEPTH (DEPTH),
        .AW    (AW),
        .DW    (PC_W + 32)
    ) u_ram (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_we    (w_wr),
        .i_waddr (r_wr_ptr),
        .i_wdata ({pc[PC_W-1:0], instr}),
        .i_raddr (w_rd_addr),
        .o_rdata (rd_data)
    );

    assign count   = r_count;
    assign busy    = w_capt;
    assign done    = (r_state == TR_DONE);
    assign timeout = r_timeout;

endmodule

// File: tb/tb_sm_trace_buf.sv
// tb_sm_trace_buf: directed self-checking bench for sm_trace_buf
// (DEPTH=8, POST=2, TIMEOUT=6). Readout expectations go through a queue.
module tb_sm_trace_buf;
    import sm_trace_buf_pkg::*;

    localparam int unsigned DEPTH   = 8;
    localparam int unsigned AW      = 3;
    localparam int unsigned PC_W    = 32;
    localparam int unsigned POST    = 2;
    localparam int unsigned TIMEOUT = 6;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              sample_en = 1'b0;
    logic [31:0]       pc = '0;
    logic [31:0]       instr = '0;
    logic              arm = 1'b0;
    logic              trig_en = 1'b0;
    logic [31:0]       trig_pc = '0;
    logic [AW-1:0]     rd_idx = '0;
    logic [PC_W+31:0]  rd_data;
    logic [AW:0]       count;
    logic              busy;
    logic              done;
    logic              timeout;

    int checks = 0;
    int errors = 0;
    logic [63:0] exp_q[$];

    sm_trace_buf #(
        .DEPTH(DEPTH), .AW(AW), .PC_W(PC_W), .POST(POST), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk), .rst_n(rst_n), .sample_en(sample_en), .pc(pc),
        .instr(instr), .arm(arm), .trig_en(trig_en), .trig_pc(trig_pc),
        .rd_idx(rd_idx), .rd_data(rd_data), .count(count), .busy(busy),
        .done(done), .timeout(timeout)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] mk_instr(input logic [31:0] p);
        return 32'hC0DE_0000 | {16'h0, p[15:0] ^ 16'h5A00};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sample(input logic [31:0] p, input logic en);
        sample_en = en;
        pc        = p;
        instr     = mk_instr(p);
        tick();
        sample_en = 1'b0;
    endtask

    task automatic pulse_arm();
        arm = 1'b1;
        tick();
        arm = 1'b0;
    endtask

    // Push the expected entry, issue the read, pop and compare one cycle later
    task automatic read_chk(input string tag, input int idx, input logic [31:0] exp_pc);
        logic [63:0] e;
        exp_q.push_back({exp_pc, mk_instr(exp_pc)});
        rd_idx = AW'(idx);
        tick();
        e = exp_q.pop_front();
        chk(tag, rd_data, e);
    endtask

    initial begin
        // ---- reset state ----
        #12;
        chk("rst_count", count, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_timeout", timeout, 0);
        chk("rst_rd_data", rd_data, 0);
        rst_n = 1'b1;
        tick();

        // ---- no arm: samples are ignored ----
        for (int i = 0; i < 20; i++) sample(32'(i), 1'b1);
        chk("idle_count", count, 0);
        chk("idle_done", done, 0);
        chk("idle_busy", busy, 0);

        // ---- basic capture: trigger at pc=2, POST=2 ----
        trig_en = 1'b1;
        trig_pc = 32'd2;
        pulse_arm();
        chk("arm_busy", busy, 1);
        for (int i = 0; i < 4; i++) sample(32'(i), 1'b1);
        chk("basic_not_done", done, 0);
        sample(32'd4, 1'b1);
        chk("basic_done", done, 1);
        chk("basic_busy", busy, 0);
        chk("basic_count", count, 5);
        sample(32'd9, 1'b1);  // frozen: ignored
        chk("basic_frozen_count", count, 5);
        for (int i = 0; i < 5; i++) read_chk($sformatf("basic_rd%0d", i), i, 32'(i));

        // ---- wrap-around: trigger at pc=15 ----
        trig_pc = 32'd15;
        pulse_arm();
        chk("wrap_rearm_done", done, 0);
        for (int i = 0; i < 20; i++) sample(32'(i), 1'b1);
        chk("wrap_done", done, 1);
        chk("wrap_count", count, 8);
        for (int i = 0; i < 8; i++) read_chk($sformatf("wrap_rd%0d", i), i, 32'(10 + i));

        // ---- sample_en gaps after trigger at pc=3 ----
        trig_pc = 32'd3;
        pulse_arm();
        for (int i = 0; i < 4; i++) sample(32'(i), 1'b1);
        sample(32'd100, 1'b0);
        sample(32'd4, 1'b1);
        sample(32'd101, 1'b0);
        chk("gap_not_done", done, 0);
        sample(32'd5, 1'b1);
        chk("gap_done", done, 1);
        chk("gap_count", count, 6);
        read_chk("gap_rd3", 3, 32'd3);
        read_chk("gap_rd4", 4, 32'd4);
        read_chk("gap_rd5", 5, 32'd5);

        // ---- arm in the same cycle as the trigger ----
        trig_pc = 32'd2;
        pulse_arm();
        sample(32'd0, 1'b1);
        sample(32'd1, 1'b1);
        arm = 1'b1;
        sample(32'd2, 1'b1);
        arm = 1'b0;
        chk("armtrig_busy", busy, 1);
        chk("armtrig_count", count, 0);
        chk("armtrig_done", done, 0);
        sample(32'd7, 1'b1);
        chk("armtrig_count1", count, 1);
        read_chk("armtrig_rd0", 0, 32'd7);

        // ---- timeout / no-trigger run ----
        trig_en = 1'b0;
        pulse_arm();
`ifdef SM_TRACE_TIMEOUT_EN
        for (int i = 0; i < 5; i++) sample(32'(i), 1'b1);
        chk("to_not_done", done, 0);
        chk("to_not_flag", timeout, 0);
        sample(32'd5, 1'b1);
        chk("to_done", done, 1);
        chk("to_flag", timeout, 1);
        chk("to_count", count, 6);
        pulse_arm();
        chk("to_flag_cleared", timeout, 0);
`else
        for (int i = 0; i < 10; i++) sample(32'(i), 1'b1);
        chk("notrig_busy", busy, 1);
        chk("notrig_done", done, 0);
        chk("notrig_timeout", timeout, 0);
        chk("notrig_count", count, 8);
        read_chk("notrig_rd0", 0, 32'd2);
`endif

        // ---- async reset mid-capture ----
        pulse_arm();
        sample(32'd1, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_busy", busy, 0);
        chk("arst_count", count, 0);
        chk("arst_rd_data", rd_data, 0);
        rst_n = 1'b1;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
